uart_tx: RTL and testbench

UART transmitter, the transmit-side counterpart of the block's existing receiver; shares its baud-select encoding and 16x-oversample timing base.
Serialises one byte per request as start bit, 8 data bits LSB first, optional parity bit, and 1 stop bit onto uart_tx_o.
Sits between the host-side byte source (register block/FIFO) and the pad.

---
 rtl/uart_tx.sv | 140 ++++++++++++++
 tb/tb_uart_tx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 stop bit.
// 16x-oversample tick base with the receiver's baud-select encoding.
module uart_tx #(
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic [2:0] buad_set_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_start_i,
  output logic       uart_tx_o,
  output logic       tx_busy_o,
  output logic       tx_done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t     state_q, state_d;
  logic [8:0] load_q, load_d;
  logic [8:0] div_q, div_d;
  logic [8:0] sel_load;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic       tx_q, tx_d;
  logic       done_q, done_d;
  logic       tick;
  logic       bit_end;

  // Divider reload values for a 16x tick at 50 MHz.
  always_comb begin
    case (buad_set_i)
      3'd1:    sel_load = 9'd324;
      3'd2:    sel_load = 9'd161;
      3'd3:    sel_load = 9'd80;
      3'd4:    sel_load = 9'd53;
      default: sel_load = 9'd26;
    endcase
  end

  assign tick    = (div_q == 9'd0);
  assign bit_end = tick && (tick_cnt_q == 4'd15);

  always_comb begin
    state_d    = state_q;
    load_d     = load_q;
    div_d      = div_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    done_d     = 1'b0;

    if (state_q == S_IDLE) begin
      if (tx_start_i) begin
        state_d    = S_START;
        load_d     = sel_load;
        div_d      = sel_load;
        tick_cnt_d = 4'd0;
        bit_idx_d  = 3'd0;
        shift_d    = tx_data_i;
        parity_d   = PARITY_ODD ? ~^tx_data_i : ^tx_data_i;
      end
    end else begin
      if (tick) begin
        div_d      = load_q;
        tick_cnt_d = tick_cnt_q + 4'd1;
      end else begin
        div_d = div_q - 9'd1;
      end

      if (bit_end) begin
        case (state_q)
          S_START: begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end
          S_DATA: begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_d = PARITY_EN ? S_PARITY : S_STOP;
            end
          end
          S_PARITY: state_d = S_STOP;
          S_STOP: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    // Line level follows the next state, so it can only move on a bit boundary.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      load_q     <= 9'd0;
      div_q      <= 9'd0;
      tick_cnt_q <= 4'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_q     <= load_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign uart_tx_o = tx_q;
  assign tx_busy_o = (state_q != S_IDLE);
  assign tx_done_o = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frames are decoded by a receiver model and compared
// against bytes queued when each request is driven.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] baud;
  logic [7:0] data;
  logic       start;
  logic       start_p;
  logic       tx, busy, done;
  logic       tx_pe, busy_pe, done_pe;
  logic       tx_po, busy_po, done_po;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       start_bit;
    logic       stop_bit;
    logic       busy_at_done;
    logic       line_at_done;
    int         glitches;
    int         busy_drops;
    int         early_done;
    int         done_k;
    int         idle_wait;
  } rx_t;

  always #5 clk = ~clk;

  uart_tx dut (
    .clk_i(clk), .rst_n(rst_n), .buad_set_i(baud), .tx_data_i(data),
    .tx_start_i(start), .uart_tx_o(tx), .tx_busy_o(busy), .tx_done_o(done)
  );

  uart_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_pe (
    .clk_i(clk), .rst_n(rst_n), .buad_set_i(baud), .tx_data_i(data),
    .tx_start_i(start_p), .uart_tx_o(tx_pe), .tx_busy_o(busy_pe), .tx_done_o(done_pe)
  );

  uart_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_po (
    .clk_i(clk), .rst_n(rst_n), .buad_set_i(baud), .tx_data_i(data),
    .tx_start_i(start_p), .uart_tx_o(tx_po), .tx_busy_o(busy_po), .tx_done_o(done_po)
  );

  function automatic logic line_of(input int sel);
    case (sel)
      0:       return tx;
      1:       return tx_pe;
      default: return tx_po;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return busy;
      1:       return busy_pe;
      default: return busy_po;
    endcase
  endfunction

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return done;
      1:       return done_pe;
      default: return done_po;
    endcase
  endfunction

  // Receiver model: called on a falling clock edge, waits for the start bit,
  // samples every clock of every bit, then looks for the done pulse.
  task automatic rx_frame(input int sel, input int p, input int nbits,
                          input bit release_start, output rx_t r);
    logic bits [0:10];
    r.data = 8'hxx; r.par = 1'bx; r.start_bit = 1'bx; r.stop_bit = 1'bx;
    r.busy_at_done = 1'bx; r.line_at_done = 1'bx;
    r.glitches = 0; r.busy_drops = 0; r.early_done = 0; r.done_k = -1; r.idle_wait = 0;
    while (line_of(sel) !== 1'b0 && r.idle_wait < 2 * p) begin
      @(negedge clk);
      r.idle_wait++;
    end
    if (line_of(sel) !== 1'b0) return;
    if (release_start) start = 1'b0;
    for (int k = 0; k < nbits * p; k++) begin
      if (k % p == 0) bits[k / p] = line_of(sel);
      else if (line_of(sel) !== bits[k / p]) r.glitches++;
      if (busy_of(sel) !== 1'b1) r.busy_drops++;
      if (done_of(sel) !== 1'b0) r.early_done++;
      @(negedge clk);
    end
    for (int w = 0; w < p; w++) begin
      if (done_of(sel) === 1'b1) begin
        r.done_k       = nbits * p + w;
        r.busy_at_done = busy_of(sel);
        r.line_at_done = line_of(sel);
        break;
      end
      @(negedge clk);
    end
    r.start_bit = bits[0];
    for (int i = 0; i < 8; i++) r.data[i] = bits[i + 1];
    r.par      = (nbits == 11) ? bits[9] : 1'b0;
    r.stop_bit = bits[nbits - 1];
  endtask

  task automatic send(input logic [2:0] b, input logic [7:0] d);
    @(negedge clk);
    baud  = b;
    data  = d;
    start = 1'b1;
    exp_q.push_back(d);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start_p = 1'b0; baud = 3'd5; data = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_line got=%b exp=1", tx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset line=%b busy=%b exp line=1 busy=0", tx, busy); end
    $display("test_reset done");
  endtask

  task automatic test_frame(input string name, input logic [2:0] b, input logic [7:0] d, input int p);
    rx_t r;
    logic [7:0] exp;
    send(b, d);
    rx_frame(0, p, 10, 1'b0, r);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (r.data !== exp) begin failures++; $display("FAIL %s_data got=%h exp=%h", name, r.data, exp); end
    checks++; if (r.start_bit !== 1'b0 || r.stop_bit !== 1'b1) begin failures++; $display("FAIL %s_framing start=%b stop=%b exp start=0 stop=1", name, r.start_bit, r.stop_bit); end
    checks++; if (r.glitches !== 0) begin failures++; $display("FAIL %s_bit_timing changes=%0d exp=0", name, r.glitches); end
    checks++; if (r.busy_drops !== 0 || r.early_done !== 0) begin failures++; $display("FAIL %s_busy busy_low=%0d early_done=%0d exp 0/0", name, r.busy_drops, r.early_done); end
    checks++; if (r.done_k !== 10 * p) begin failures++; $display("FAIL %s_frame_len got=%0d exp=%0d", name, r.done_k, 10 * p); end
    checks++; if (r.busy_at_done !== 1'b0) begin failures++; $display("FAIL %s_busy_at_done got=%b exp=0", name, r.busy_at_done); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s_done_width got=%b exp=0", name, done); end
    $display("test_frame %s data=%h len=%0d", name, r.data, r.done_k);
  endtask

  task automatic test_baud_table();
    logic [2:0] sel [3] = '{3'd2, 3'd3, 3'd4};
    int         per [3] = '{2592, 1296, 864};
    int cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      baud = sel[i]; data = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt = 0;
      while (tx === 1'b0 && cnt < 2 * per[i]) begin
        cnt++;
        @(negedge clk);
      end
      checks++; if (cnt !== per[i]) begin failures++; $display("FAIL baud%0d_start_len got=%0d exp=%0d", sel[i], cnt, per[i]); end
      #1 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      $display("test_baud_table sel=%0d start_bit_clocks=%0d", sel[i], cnt);
    end
  endtask

  task automatic test_parity();
    rx_t re, ro;
    @(negedge clk);
    baud = 3'd5; data = 8'h07; start_p = 1'b1;
    @(negedge clk);
    start_p = 1'b0;
    fork
      rx_frame(1, 432, 11, 1'b0, re);
      rx_frame(2, 432, 11, 1'b0, ro);
    join
    checks++; if (re.data !== 8'h07 || ro.data !== 8'h07) begin failures++; $display("FAIL parity_data even=%h odd=%h exp=07", re.data, ro.data); end
    checks++; if (re.par !== 1'b1) begin failures++; $display("FAIL parity_even_bit got=%b exp=1", re.par); end
    checks++; if (ro.par !== 1'b0) begin failures++; $display("FAIL parity_odd_bit got=%b exp=0", ro.par); end
    checks++; if (re.done_k !== 4752 || ro.done_k !== 4752) begin failures++; $display("FAIL parity_frame_len even=%0d odd=%0d exp=4752", re.done_k, ro.done_k); end
    checks++; if (re.glitches !== 0 || ro.glitches !== 0 || re.stop_bit !== 1'b1 || ro.stop_bit !== 1'b1) begin failures++; $display("FAIL parity_timing even_changes=%0d odd_changes=%0d stop=%b/%b exp 0/0 1/1", re.glitches, ro.glitches, re.stop_bit, ro.stop_bit); end
    $display("test_parity even_par=%b odd_par=%b len=%0d", re.par, ro.par, re.done_k);
  endtask

  task automatic test_back_to_back();
    rx_t r;
    logic [7:0] exp;
    int extra;
    @(negedge clk);
    baud = 3'd5; data = 8'h55; start = 1'b1;
    repeat (3) exp_q.push_back(8'h55);
    for (int f = 0; f < 3; f++) begin
      rx_frame(0, 432, 10, (f == 2), r);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++; if (r.data !== exp || r.done_k !== 4320) begin failures++; $display("FAIL b2b%0d_frame data=%h len=%0d exp data=%h len=4320", f, r.data, r.done_k, exp); end
      checks++; if (r.line_at_done !== 1'b1) begin failures++; $display("FAIL b2b%0d_line_at_done got=%b exp=1", f, r.line_at_done); end
      if (f > 0) begin
        checks++; if (r.idle_wait !== 1) begin failures++; $display("FAIL b2b%0d_gap got=%0d exp=1", f, r.idle_wait); end
      end
      $display("test_back_to_back frame=%0d data=%h gap=%0d", f, r.data, r.idle_wait);
    end
    extra = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL b2b_no_fourth busy_cycles=%0d exp=0", extra); end
  endtask

  task automatic test_midframe();
    rx_t r;
    logic [7:0] exp;
    int extra;
    send(3'd5, 8'h3C);
    fork
      rx_frame(0, 432, 10, 1'b0, r);
      begin
        repeat (1500) @(negedge clk);
        baud = 3'd1; data = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++; if (r.data !== exp) begin failures++; $display("FAIL mid_data got=%h exp=%h", r.data, exp); end
    checks++; if (r.done_k !== 4320 || r.glitches !== 0) begin failures++; $display("FAIL mid_timing len=%0d changes=%0d exp len=4320 changes=0", r.done_k, r.glitches); end
    extra = 0;
    repeat (200) begin
      @(negedge clk);
      if (busy !== 1'b0 || tx !== 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL mid_request_ignored busy_cycles=%0d exp=0", extra); end
    $display("test_midframe data=%h len=%0d", r.data, r.done_k);
  endtask

  task automatic test_reset_midframe();
    int bad_done;
    @(negedge clk);
    baud = 3'd5; data = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4 * 432 + 200) @(negedge clk);
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL rstmid_line_before got=%b exp=0", tx); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL rstmid_line_async got=%b exp=1", tx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy_async got=%b exp=0", busy); end
    bad_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (done !== 1'b0) bad_done++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad_done++;
    end
    checks++; if (bad_done !== 0) begin failures++; $display("FAIL rstmid_no_done bad_cycles=%0d exp=0", bad_done); end
    $display("test_reset_midframe bad_cycles=%0d", bad_done);
    test_frame("after_rst", 3'd5, 8'h96, 432);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame("a5_115200", 3'd5, 8'hA5, 432);
    test_frame("00_9600", 3'd1, 8'h00, 5200);
    test_baud_table();
    test_parity();
    test_back_to_back();
    test_midframe();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
